pipe_stall_ctrl: RTL and testbench

// Central stall/interlock controller for the 3-stage pipeline. Tracks outstanding I$/D$ requests,

---
 rtl/pipe_stall_ctrl_pkg.sv | 31 +++
 rtl/pipe_stall_ctrl_pend.sv | 23 ++
 rtl/pipe_stall_ctrl.sv | 104 ++++++++++
 tb/tb_pipe_stall_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall/interlock controller.
// Pending-miss state encoding and register-address helpers.
package pipe_stall_ctrl_pkg;

    localparam int REG_ADDR_W = 5;

    // Miss-wait state is simply {d_pend, i_pend}.
    typedef enum logic [1:0] {
        RUN     = 2'b00,
        WAIT_I  = 2'b01,
        WAIT_D  = 2'b10,
        WAIT_ID = 2'b11
    } pend_state_e;

    function automatic logic waits_on_i(input pend_state_e s);
        return (s == WAIT_I) || (s == WAIT_ID);
    endfunction

    function automatic logic waits_on_d(input pend_state_e s);
        return (s == WAIT_D) || (s == WAIT_ID);
    endfunction

    function automatic logic src_hazard(
        input logic                  used,
        input logic [REG_ADDR_W-1:0] src,
        input logic [REG_ADDR_W-1:0] rd
    );
        return used && (src == rd);
    endfunction

endpackage

// File: rtl/pipe_stall_ctrl_pend.sv
// Per-cache outstanding-request bit: set on accept, cleared by response.
// Latency: 1 cycle. Backpressure: none; it only observes handshakes.
module pend_tracker (
    input  logic clk,
    input  logic reset,
    input  logic accept,
    input  logic resp_valid,
    output logic pend
);

    // A response arriving with a new accept belongs to the older request,
    // so accept wins and the bit stays set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend <= 1'b0;
        end else if (accept) begin
            pend <= 1'b1;
        end else if (resp_valid) begin
            pend <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Global stall / load-use interlock controller with stall perf counters and hang watchdog.
// Latency: stall/interlock combinational, stall_release and counters 1 cycle. Backpressure: stall freezes the pipe.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  icache_req_valid,
    input  logic                  icache_req_ready,
    input  logic                  icache_resp_valid,
    input  logic                  dcache_req_valid,
    input  logic                  dcache_req_ready,
    input  logic                  dcache_resp_valid,
    input  logic [REG_ADDR_W-1:0] rs1_addr_D,
    input  logic [REG_ADDR_W-1:0] rs2_addr_D,
    input  logic                  rs1_used_D,
    input  logic                  rs2_used_D,
    input  logic [REG_ADDR_W-1:0] rd_addr_X,
    input  logic                  load_X,
    output logic                  stall,
    output logic                  interlock,
    output logic                  stall_release,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      miss_count,
    output logic                  hang_err
);

    localparam int               RUN_W   = $clog2(TIMEOUT + 1);
    localparam logic [RUN_W-1:0] RUN_SAT = RUN_W'(TIMEOUT);
    localparam logic [RUN_W-1:0] HANG_AT = RUN_W'(TIMEOUT - 1);

    logic             i_accept;
    logic             d_accept;
    logic             i_pend;
    logic             d_pend;
    pend_state_e      pend_state;
    logic             stall_q;
    logic [RUN_W-1:0] run_len;

    assign i_accept = icache_req_valid & icache_req_ready;
    assign d_accept = dcache_req_valid & dcache_req_ready;

    pend_tracker u_i_pend (
        .clk        (clk),
        .reset      (reset),
        .accept     (i_accept),
        .resp_valid (icache_resp_valid),
        .pend       (i_pend)
    );

    pend_tracker u_d_pend (
        .clk        (clk),
        .reset      (reset),
        .accept     (d_accept),
        .resp_valid (dcache_resp_valid),
        .pend       (d_pend)
    );

    assign pend_state = pend_state_e'({d_pend, i_pend});

    // The response cycle itself advances the pipe, so a pending miss only
    // stalls while its response is still absent.
    assign stall = (icache_req_valid & ~icache_req_ready)
                 | (dcache_req_valid & ~dcache_req_ready)
                 | (waits_on_i(pend_state) & ~icache_resp_valid)
                 | (waits_on_d(pend_state) & ~dcache_resp_valid);

    assign interlock = ~stall & load_X & (rd_addr_X != '0)
                     & (src_hazard(rs1_used_D, rs1_addr_D, rd_addr_X)
                      | src_hazard(rs2_used_D, rs2_addr_D, rd_addr_X));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q       <= 1'b0;
            stall_release <= 1'b0;
            stall_cycles  <= '0;
            miss_count    <= '0;
            run_len       <= '0;
            hang_err      <= 1'b0;
        end else begin
            stall_q       <= stall;
            stall_release <= stall_q & ~stall;
            if (stall) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (stall & ~stall_q) begin
                miss_count <= miss_count + CNT_W'(1);
            end
            if (!stall) begin
                run_len <= '0;
            end else if (run_len != RUN_SAT) begin
                run_len <= run_len + RUN_W'(1);
            end
            // run_len == TIMEOUT-1 while stalled is the TIMEOUT-th consecutive stall cycle.
            if (stall && (run_len >= HANG_AT)) begin
                hang_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
module tb_pipe_stall_ctrl;

    localparam int CNT_W   = 32;
    localparam int TIMEOUT = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             icache_req_valid, icache_req_ready, icache_resp_valid;
    logic             dcache_req_valid, dcache_req_ready, dcache_resp_valid;
    logic [4:0]       rs1_addr_D, rs2_addr_D, rd_addr_X;
    logic             rs1_used_D, rs2_used_D, load_X;
    logic             stall, interlock, stall_release, hang_err;
    logic [CNT_W-1:0] stall_cycles, miss_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stall_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk               (clk),
        .reset             (reset),
        .icache_req_valid  (icache_req_valid),
        .icache_req_ready  (icache_req_ready),
        .icache_resp_valid (icache_resp_valid),
        .dcache_req_valid  (dcache_req_valid),
        .dcache_req_ready  (dcache_req_ready),
        .dcache_resp_valid (dcache_resp_valid),
        .rs1_addr_D        (rs1_addr_D),
        .rs2_addr_D        (rs2_addr_D),
        .rs1_used_D        (rs1_used_D),
        .rs2_used_D        (rs2_used_D),
        .rd_addr_X         (rd_addr_X),
        .load_X            (load_X),
        .stall             (stall),
        .interlock         (interlock),
        .stall_release     (stall_release),
        .stall_cycles      (stall_cycles),
        .miss_count        (miss_count),
        .hang_err          (hang_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: outstanding-miss flags plus plain integer bookkeeping.
    bit          m_i_out, m_d_out, m_prev_stall, m_release, m_hang;
    bit [31:0]   m_stall_cycles, m_misses;
    int          m_run;

    function automatic bit m_stall();
        return (icache_req_valid && !icache_req_ready)
            || (dcache_req_valid && !dcache_req_ready)
            || (m_i_out && !icache_resp_valid)
            || (m_d_out && !dcache_resp_valid);
    endfunction

    function automatic bit m_interlock();
        bit hit;
        hit = (rs1_used_D && rs1_addr_D == rd_addr_X) || (rs2_used_D && rs2_addr_D == rd_addr_X);
        return !m_stall() && load_X && rd_addr_X != 0 && hit;
    endfunction

    task automatic model_reset();
        m_i_out = 0; m_d_out = 0; m_prev_stall = 0; m_release = 0; m_hang = 0;
        m_stall_cycles = 0; m_misses = 0; m_run = 0;
    endtask

    task automatic model_step();
        bit s;
        s = m_stall();
        if (icache_req_valid && icache_req_ready) m_i_out = 1;
        else if (icache_resp_valid)               m_i_out = 0;
        if (dcache_req_valid && dcache_req_ready) m_d_out = 1;
        else if (dcache_resp_valid)               m_d_out = 0;
        if (s) m_stall_cycles++;
        if (s && !m_prev_stall) m_misses++;
        m_release = m_prev_stall && !s;
        m_run = s ? m_run + 1 : 0;
        if (m_run >= TIMEOUT) m_hang = 1;
        m_prev_stall = s;
    endtask

    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (reset) model_reset();
            chk("model_stall", stall, m_stall());
            chk("model_interlock", interlock, m_interlock());
            chk("model_release", stall_release, m_release);
            chk("model_stall_cycles", stall_cycles, m_stall_cycles);
            chk("model_miss_count", miss_count, m_misses);
            chk("model_hang_err", hang_err, m_hang);
            @(posedge clk);
            if (!reset) model_step();
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        icache_req_valid = 0; icache_req_ready = 0; icache_resp_valid = 0;
        dcache_req_valid = 0; dcache_req_ready = 0; dcache_resp_valid = 0;
        rs1_addr_D = 0; rs2_addr_D = 0; rs1_used_D = 0; rs2_used_D = 0;
        rd_addr_X = 0; load_X = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        step();
        reset = 0;
    endtask

    initial begin
        idle();
        reset = 1;
        step();
        step();
        reset = 0;

        // Reset in the middle of a double miss.
        icache_req_valid = 1; icache_req_ready = 1;
        dcache_req_valid = 1; dcache_req_ready = 1;
        #2 chk("accept_not_stall", stall, 0);
        step(); idle();
        #2 chk("wait_id_stall", stall, 1);
        step();
        #2 chk("wait_id_cycles_before_rst", stall_cycles, 1);
        reset = 1;
        #1;
        chk("rst_stall_immediate", stall, 0);
        chk("rst_stall_cycles", stall_cycles, 0);
        chk("rst_miss_count", miss_count, 0);
        step(); reset = 0;
        step();
        #2 chk("rst_dropped_pending", stall, 0);

        // D$ accept t0, response t3.
        do_reset();
        dcache_req_valid = 1; dcache_req_ready = 1;
        step(); idle();
        #2 chk("d_t1_stall", stall, 1);
        step();
        #2 chk("d_t2_stall", stall, 1);
        step(); dcache_resp_valid = 1;
        #2 chk("d_t3_resp_no_stall", stall, 0);
        step(); idle();
        #2 chk("d_t4_release", stall_release, 1);
        chk("d_t4_stall_cycles", stall_cycles, 2);
        chk("d_t4_miss_count", miss_count, 1);
        step();
        #2 chk("d_t5_release_pulse", stall_release, 0);

        // Both caches accepted at t0, I$ responds t2, D$ t4: one episode.
        do_reset();
        icache_req_valid = 1; icache_req_ready = 1;
        dcache_req_valid = 1; dcache_req_ready = 1;
        step(); idle();
        #2 chk("id_t1_stall", stall, 1);
        step(); icache_resp_valid = 1;
        #2 chk("id_t2_stall_d_pending", stall, 1);
        step(); idle();
        #2 chk("id_t3_stall", stall, 1);
        step(); dcache_resp_valid = 1;
        #2 chk("id_t4_no_stall", stall, 0);
        step(); idle();
        #2 chk("id_t5_miss_count", miss_count, 1);
        chk("id_t5_stall_cycles", stall_cycles, 3);
        chk("id_t5_release", stall_release, 1);

        // Load-use interlock patterns with no misses.
        do_reset();
        load_X = 1; rd_addr_X = 5; rs2_used_D = 1; rs2_addr_D = 5; rs1_used_D = 1; rs1_addr_D = 3;
        #2 chk("il_rs2_hit", interlock, 1);
        chk("il_rs2_no_stall", stall, 0);
        step(); load_X = 0;
        #2 chk("il_bubble_gone", interlock, 0);
        step(); load_X = 1; rd_addr_X = 0; rs1_addr_D = 0; rs2_addr_D = 0;
        #2 chk("il_rd_zero", interlock, 0);
        step(); rd_addr_X = 7; rs1_addr_D = 7; rs2_used_D = 0;
        #2 chk("il_rs1_hit", interlock, 1);
        step(); rs1_used_D = 0;
        #2 chk("il_rs1_unused", interlock, 0);

        // Same hazard while a D$ miss is outstanding.
        do_reset();
        dcache_req_valid = 1; dcache_req_ready = 1;
        step(); idle();
        load_X = 1; rd_addr_X = 5; rs2_used_D = 1; rs2_addr_D = 5;
        #2 chk("il_during_stall", interlock, 0);
        chk("il_stall_active", stall, 1);
        step(); dcache_resp_valid = 1;
        #2 chk("il_resp_cycle", interlock, 1);
        chk("il_resp_no_stall", stall, 0);
        step(); idle();

        // Not-ready request, back-to-back accept with response, stray response.
        do_reset();
        icache_req_valid = 1;
        #2 chk("i_not_ready_stall", stall, 1);
        step(); icache_req_ready = 1;
        step(); idle();
        step(); icache_resp_valid = 1; icache_req_valid = 1; icache_req_ready = 1;
        #2 chk("i_accept_with_resp", stall, 0);
        step(); idle();
        #2 chk("i_new_req_pending", stall, 1);
        step(); icache_resp_valid = 1;
        step(); idle();
        step(); dcache_resp_valid = 1;
        step(); idle();
        #2 chk("stray_resp_ignored", stall, 0);

        // Watchdog: D$ never answers for TIMEOUT cycles.
        do_reset();
        dcache_req_valid = 1; dcache_req_ready = 1;
        step(); idle();
        for (int i = 1; i <= TIMEOUT; i++) begin
            #2 chk("hang_not_yet", hang_err, 0);
            step();
        end
        #2 chk("hang_set", hang_err, 1);
        chk("hang_still_stalled", stall, 1);
        dcache_resp_valid = 1;
        step(); idle();
        #2 chk("hang_sticky", hang_err, 1);
        chk("hang_stall_cycles", stall_cycles, TIMEOUT);
        chk("hang_release", stall_release, 1);
        step();
        #2 chk("hang_sticky_later", hang_err, 1);
        do_reset();
        #2 chk("hang_cleared_by_reset", hang_err, 0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
